// File: rtl/cache_ctrl.sv
// cache_ctrl: single-lookup sequencing controller for the set-associative cache.
// Accepts one lookup, answers hits from the cache read port, and services misses
// by fetching from memory and refilling a victim way through the cache write port.
// Optional feature macro: CACHE_CTRL_INVALID_FIRST_EN (prefer the lowest invalid way as victim).

package cache_pkg;
    localparam int NumSets       = 4;
    localparam int SetWidth      = 2;
    localparam int TagWidth      = 4;
    localparam int Associativity = 3;
    localparam int WayWidth      = 2;
    localparam int DataWidth     = 16;

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef logic [DataWidth-1:0] block_data_t;
endpackage

module cache_ctrl
    import cache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [SetWidth-1:0]   req_set_i,
    input  logic [TagWidth-1:0]   req_tag_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_hit_o,
    output logic [DataWidth-1:0]  resp_data_o,

    output logic [SetWidth-1:0]   cache_read_set_o,
    output logic [TagWidth-1:0]   cache_read_tag_o,
    input  logic                  cache_read_hit_i,
    input  logic [DataWidth-1:0]  cache_read_data_i,
    input  block_info_t           cache_read_info_i [Associativity],
    output logic                  cache_write_en_o,
    output logic [SetWidth-1:0]   cache_write_set_o,
    output block_info_t           cache_write_info_o [Associativity],
    output logic [WayWidth-1:0]   cache_write_data_way_o,
    output logic [DataWidth-1:0]  cache_write_data_o,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [SetWidth-1:0]   mem_req_set_o,
    output logic [TagWidth-1:0]   mem_req_tag_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DataWidth-1:0]  mem_resp_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_FILL,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SetWidth-1:0]  r_set;
    logic [TagWidth-1:0]  r_tag;
    logic [DataWidth-1:0] r_data;
    block_info_t          r_info [Associativity];
    logic [WayWidth-1:0]  r_victim;
    logic                 r_hit;
    logic [WayWidth-1:0]  r_rr_ptr;
    logic [WayWidth-1:0]  w_victim;
    logic [WayWidth-1:0]  w_rr_nxt;
    logic                 w_accept;

    assign w_accept = (r_state == S_IDLE) && req_valid_i;

    // Round-robin pointer wraps explicitly so a non-power-of-2 way count stays in range
    assign w_rr_nxt = (r_rr_ptr == WayWidth'(Associativity - 1)) ? '0 : r_rr_ptr + WayWidth'(1);

    // Victim choice for the current lookup, taken from the info the cache presents now
    always_comb begin
        w_victim = r_rr_ptr;
`ifdef CACHE_CTRL_INVALID_FIRST_EN
        for (int w = Associativity - 1; w >= 0; w--) begin
            if (!cache_read_info_i[w].valid) begin
                w_victim = WayWidth'(w);
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_LOOKUP;
            S_LOOKUP:   w_state_nxt = cache_read_hit_i ? S_RESP : S_MEM_REQ;
            S_MEM_REQ:  if (mem_req_ready_i) w_state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_resp_valid_i) w_state_nxt = S_FILL;
            S_FILL:     w_state_nxt = S_RESP;
            S_RESP:     if (resp_ready_i) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Request, lookup and fetch registers plus the shared replacement pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_set    <= '0;
            r_tag    <= '0;
            r_data   <= '0;
            r_victim <= '0;
            r_hit    <= 1'b0;
            r_rr_ptr <= '0;
            for (int w = 0; w < Associativity; w++) begin
                r_info[w] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_set <= req_set_i;
                        r_tag <= req_tag_i;
                    end
                end
                S_LOOKUP: begin
                    r_hit <= cache_read_hit_i;
                    if (cache_read_hit_i) begin
                        r_data <= cache_read_data_i;
                    end else begin
                        r_victim <= w_victim;
                        for (int w = 0; w < Associativity; w++) begin
                            r_info[w] <= cache_read_info_i[w];
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid_i) begin
                        r_data <= mem_resp_data_i;
                    end
                end
                S_FILL: begin
                    r_hit    <= 1'b0;
                    r_rr_ptr <= w_rr_nxt;
                end
                default: ;
            endcase
        end
    end

    // Output decode; handshake strobes are forced low while reset is held
    always_comb begin
        req_ready_o            = (r_state == S_IDLE) && !rst_i;
        resp_valid_o           = (r_state == S_RESP) && !rst_i;
        resp_hit_o             = r_hit && !rst_i;
        resp_data_o            = r_data;
        mem_req_valid_o        = (r_state == S_MEM_REQ) && !rst_i;
        mem_req_set_o          = r_set;
        mem_req_tag_o          = r_tag;
        cache_read_set_o       = r_set;
        cache_read_tag_o       = r_tag;
        cache_write_en_o       = 1'b0;
        cache_write_set_o      = '0;
        cache_write_data_way_o = '0;
        cache_write_data_o     = '0;
        for (int w = 0; w < Associativity; w++) begin
            cache_write_info_o[w] = '0;
        end
        if (r_state == S_FILL) begin
            cache_write_en_o       = !rst_i;
            cache_write_set_o      = r_set;
            cache_write_data_way_o = r_victim;
            cache_write_data_o     = r_data;
            for (int w = 0; w < Associativity; w++) begin
                if (WayWidth'(w) == r_victim) begin
                    cache_write_info_o[w].valid = 1'b1;
                    cache_write_info_o[w].tag   = r_tag;
                end else begin
                    cache_write_info_o[w] = r_info[w];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized self-checking bench for cache_ctrl with an emulated cache
// array, a memory responder and a transaction-level reference model.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [SetWidth-1:0]   req_set;
    logic [TagWidth-1:0]   req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [DataWidth-1:0]  resp_data;
    logic [SetWidth-1:0]   rd_set;
    logic [TagWidth-1:0]   rd_tag;
    logic                  rd_hit;
    logic [DataWidth-1:0]  rd_data;
    block_info_t           rd_info [Associativity];
    logic                  wr_en;
    logic [SetWidth-1:0]   wr_set;
    block_info_t           wr_info [Associativity];
    logic [WayWidth-1:0]   wr_way;
    logic [DataWidth-1:0]  wr_data;
    logic                  mreq_valid;
    logic                  mreq_ready;
    logic [SetWidth-1:0]   mreq_set;
    logic [TagWidth-1:0]   mreq_tag;
    logic                  mresp_valid;
    logic [DataWidth-1:0]  mresp_data;

    // emulated cache array (follows what the DUT writes) and bench preload port
    logic                  em_valid [NumSets][Associativity];
    logic [TagWidth-1:0]   em_tag   [NumSets][Associativity];
    logic [DataWidth-1:0]  em_data  [NumSets][Associativity];
    logic                  em_clr;
    logic                  pre_en;
    logic [SetWidth-1:0]   pre_set;
    int                    pre_way;
    logic                  pre_valid;
    logic [TagWidth-1:0]   pre_tag;
    logic [DataWidth-1:0]  pre_data;
    int                    fill_cnt;

    // reference model state
    logic                  ref_valid [NumSets][Associativity];
    int                    ref_tag   [NumSets][Associativity];
    logic [DataWidth-1:0]  ref_data  [NumSets][Associativity];
    int                    ref_rr;
    logic [DataWidth-1:0]  mem_arr   [NumSets][16];

    int n_tests;
    int n_fail;

    cache_ctrl u_dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .req_valid_i            (req_valid),
        .req_ready_o            (req_ready),
        .req_set_i              (req_set),
        .req_tag_i              (req_tag),
        .resp_valid_o           (resp_valid),
        .resp_ready_i           (resp_ready),
        .resp_hit_o             (resp_hit),
        .resp_data_o            (resp_data),
        .cache_read_set_o       (rd_set),
        .cache_read_tag_o       (rd_tag),
        .cache_read_hit_i       (rd_hit),
        .cache_read_data_i      (rd_data),
        .cache_read_info_i      (rd_info),
        .cache_write_en_o       (wr_en),
        .cache_write_set_o      (wr_set),
        .cache_write_info_o     (wr_info),
        .cache_write_data_way_o (wr_way),
        .cache_write_data_o     (wr_data),
        .mem_req_valid_o        (mreq_valid),
        .mem_req_ready_i        (mreq_ready),
        .mem_req_set_o          (mreq_set),
        .mem_req_tag_o          (mreq_tag),
        .mem_resp_valid_i       (mresp_valid),
        .mem_resp_data_i        (mresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational cache read port
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int w = 0; w < Associativity; w++) begin
            rd_info[w].valid = em_valid[rd_set][w];
            rd_info[w].tag   = em_tag[rd_set][w];
            if (em_valid[rd_set][w] && em_tag[rd_set][w] == rd_tag) begin
                rd_hit  = 1'b1;
                rd_data = em_data[rd_set][w];
            end
        end
    end

    // cache array update from the DUT write port or bench preload
    always @(posedge clk) begin
        if (em_clr) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < Associativity; w++) begin
                    em_valid[s][w] <= 1'b0;
                    em_tag[s][w]   <= '0;
                    em_data[s][w]  <= '0;
                end
            end
            fill_cnt <= 0;
        end else begin
            if (wr_en) begin
                for (int w = 0; w < Associativity; w++) begin
                    em_valid[wr_set][w] <= wr_info[w].valid;
                    em_tag[wr_set][w]   <= wr_info[w].tag;
                end
                em_data[wr_set][int'(wr_way)] <= wr_data;
                fill_cnt <= fill_cnt + 1;
            end
            if (pre_en) begin
                em_valid[pre_set][pre_way] <= pre_valid;
                em_tag[pre_set][pre_way]   <= pre_tag;
                em_data[pre_set][pre_way]  <= pre_data;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one complete transaction with model prediction and protocol checks
    task automatic txn(input int s, input int t, input int mrdy_wait, input int mlat, input int rrdy_wait);
        logic                 exp_hit;
        int                   hw;
        int                   vic;
        logic                 found;
        logic [DataWidth-1:0] exp_data;
        int                   fc0;
        exp_hit = 1'b0;
        hw      = 0;
        for (int w = 0; w < Associativity; w++) begin
            if (ref_valid[s][w] && ref_tag[s][w] == t) begin
                exp_hit = 1'b1;
                hw      = w;
            end
        end
        fc0 = fill_cnt;
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_set   = SetWidth'(s);
        req_tag   = TagWidth'(t);
        step();
        req_valid = 1'b0;
        check("lookup_ready", 32'(req_ready), 32'd0);
        check("rd_set", 32'(rd_set), 32'(s));
        check("rd_tag", 32'(rd_tag), 32'(t));
        check("lookup_mreq", 32'(mreq_valid), 32'd0);
        check("lookup_resp", 32'(resp_valid), 32'd0);
        step();
        if (exp_hit) begin
            exp_data = ref_data[s][hw];
            check("hit_no_mreq", 32'(mreq_valid), 32'd0);
        end else begin
            vic = ref_rr;
`ifdef CACHE_CTRL_INVALID_FIRST_EN
            found = 1'b0;
            for (int w = 0; w < Associativity; w++) begin
                if (!found && !ref_valid[s][w]) begin
                    vic   = w;
                    found = 1'b1;
                end
            end
`else
            found = 1'b0;
`endif
            for (int i = 0; i < mrdy_wait; i++) begin
                check("mreq_hold_v", 32'(mreq_valid), 32'd1);
                check("mreq_hold_set", 32'(mreq_set), 32'(s));
                check("mreq_hold_tag", 32'(mreq_tag), 32'(t));
                check("mreq_hold_rdy", 32'(req_ready), 32'd0);
                step();
            end
            check("mreq_v", 32'(mreq_valid), 32'd1);
            check("mreq_set", 32'(mreq_set), 32'(s));
            check("mreq_tag", 32'(mreq_tag), 32'(t));
            mreq_ready = 1'b1;
            step();
            mreq_ready = 1'b0;
            check("mwait_mreq", 32'(mreq_valid), 32'd0);
            for (int i = 0; i < mlat; i++) begin
                check("mwait_nowr", 32'(wr_en), 32'd0);
                step();
            end
            mresp_valid = 1'b1;
            mresp_data  = mem_arr[s][t];
            step();
            mresp_valid = 1'b0;
            ref_valid[s][vic] = 1'b1;
            ref_tag[s][vic]   = t;
            ref_data[s][vic]  = mem_arr[s][t];
            ref_rr            = (ref_rr + 1) % Associativity;
            exp_data          = mem_arr[s][t];
            check("fill_en", 32'(wr_en), 32'd1);
            check("fill_set", 32'(wr_set), 32'(s));
            check("fill_way", 32'(wr_way), 32'(vic));
            check("fill_data", 32'(wr_data), 32'(exp_data));
            for (int w = 0; w < Associativity; w++) begin
                check("fill_info", 32'({wr_info[w].valid, wr_info[w].tag}),
                      32'({ref_valid[s][w], TagWidth'(ref_tag[s][w])}));
            end
            check("fill_noresp", 32'(resp_valid), 32'd0);
            step();
        end
        for (int i = 0; i <= rrdy_wait; i++) begin
            check("resp_v", 32'(resp_valid), 32'd1);
            check("resp_hit", 32'(resp_hit), 32'(exp_hit));
            check("resp_data", 32'(resp_data), 32'(exp_data));
            check("resp_rdy", 32'(req_ready), 32'd0);
            if (i < rrdy_wait) step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("post_resp_v", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
        check("fill_count", 32'(fill_cnt - fc0), exp_hit ? 32'd0 : 32'd1);
    endtask

    task automatic preload(input int s, input int w, input logic v, input int t);
        pre_en    = 1'b1;
        pre_set   = SetWidth'(s);
        pre_way   = w;
        pre_valid = v;
        pre_tag   = TagWidth'(t);
        pre_data  = mem_arr[s][t];
        step();
        pre_en = 1'b0;
        ref_valid[s][w] = v;
        ref_tag[s][w]   = t;
        ref_data[s][w]  = mem_arr[s][t];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fc0;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        em_clr      = 1'b1;
        req_valid   = 1'b0;
        req_set     = '0;
        req_tag     = '0;
        resp_ready  = 1'b0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
        pre_en      = 1'b0;
        pre_set     = '0;
        pre_way     = 0;
        pre_valid   = 1'b0;
        pre_tag     = '0;
        pre_data    = '0;
        ref_rr      = 0;
        for (int s = 0; s < NumSets; s++) begin
            for (int t = 0; t < 16; t++) mem_arr[s][t] = DataWidth'($urandom);
            for (int w = 0; w < Associativity; w++) begin
                ref_valid[s][w] = 1'b0;
                ref_tag[s][w]   = 0;
                ref_data[s][w]  = '0;
            end
        end
        mem_arr[3][5] = 16'hA5A5;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_v", 32'(resp_valid), 32'd0);
        check("rst_mreq_v", 32'(mreq_valid), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_hit", 32'(resp_hit), 32'd0);
        rst    = 1'b0;
        em_clr = 1'b0;
        step();

        // cold miss then hit on the same line
        txn(3, 5, 0, 3, 0);
        txn(3, 5, 0, 1, 0);

        // reset while waiting on memory abandons the fill
        check("ab_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_set   = 2'd2;
        req_tag   = 4'd7;
        step();
        req_valid = 1'b0;
        step();
        check("ab_mreq", 32'(mreq_valid), 32'd1);
        mreq_ready = 1'b1;
        step();
        mreq_ready = 1'b0;
        fc0 = fill_cnt;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("ab_rst_ready", 32'(req_ready), 32'd0);
            check("ab_rst_resp", 32'(resp_valid), 32'd0);
            check("ab_rst_wr", 32'(wr_en), 32'd0);
            check("ab_rst_mreq", 32'(mreq_valid), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ab_rel_ready", 32'(req_ready), 32'd1);
        mresp_valid = 1'b1;
        mresp_data  = 16'hDEAD;
        step();
        mresp_valid = 1'b0;
        check("ab_stale_wr", 32'(wr_en), 32'd0);
        check("ab_stale_ready", 32'(req_ready), 32'd1);
        step();
        check("ab_fill_cnt", 32'(fill_cnt - fc0), 32'd0);
        ref_rr = 0;

        // replacement order on one set, then the evicted tag misses again
        for (int t = 0; t <= Associativity; t++) txn(0, t, 0, 1, 0);
        txn(0, 0, 0, 2, 0);

        // preload set 1 with way 2 invalid, pointer at 0
        rst = 1'b1;
        step();
        rst    = 1'b0;
        ref_rr = 0;
        preload(1, 0, 1'b1, 1);
        preload(1, 1, 1'b1, 2);
        preload(1, 2, 1'b0, 0);
        txn(1, 9, 0, 1, 0);
        txn(1, 10, 0, 1, 0);

        // back-pressure on both the fetch and the response
        txn(2, 11, 5, 2, 4);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            txn(int'($urandom_range(0, NumSets - 1)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
